// File: rtl/tiny_shader_pkg.sv
// tiny_shader_pkg: shared constants and loader state encoding for the shader program loader.
package tiny_shader_pkg;
    localparam int NUM_INSTR_DEF = 16;
    localparam int INSTR_W       = 8;

    typedef enum logic [1:0] {IDLE, ARMED, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through head and synchronous flush.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/shader_program_loader.sv
// shader_program_loader: buffers a shader program and swaps it into shader memory during vblank,
// passing execute-driven shifts straight through outside the load burst.
module shader_program_loader
    import tiny_shader_pkg::*;
#(
    parameter int NUM_INSTR = NUM_INSTR_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INSTR_W-1:0] wr_instr_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic               commit_i,
    input  logic               vblank_i,
    input  logic               execute_i,
    output logic               mem_shift_o,
    output logic               mem_load_o,
    output logic [INSTR_W-1:0] mem_instr_o,
    output logic               busy_o,
    output logic               swap_done_o,
    output logic               error_o
);
    localparam int CW = $clog2(NUM_INSTR) + 1;

    loader_state_t      state_q, state_d;
    logic               error_q, error_d;
    logic               push, pop, flush, full, empty;
    logic [CW-1:0]      count, count_after;
    logic [INSTR_W-1:0] head;

    sync_fifo #(.DEPTH(NUM_INSTR), .WIDTH(INSTR_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (wr_instr_i),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign push        = wr_valid_i && wr_ready_o;
    assign count_after = count + CW'(push);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    // The burst ends when the last buffered word is being popped.
    always_comb begin
        state_d = state_q;
        error_d = error_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: if (commit_i) begin
                if (count_after == CW'(NUM_INSTR)) state_d = ARMED;
                else begin
                    flush   = 1'b1;
                    error_d = 1'b1;
                end
            end
            ARMED: if (vblank_i && !execute_i) state_d = LOAD;
            LOAD: begin
                if (execute_i) error_d = 1'b1;
                if (count == CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready_o  = (state_q == IDLE) && !full;
        pop         = (state_q == LOAD) && !empty;
        mem_load_o  = state_q == LOAD;
        mem_shift_o = (state_q == LOAD) ? 1'b1 : execute_i;
        mem_instr_o = head;
        busy_o      = state_q != IDLE;
        swap_done_o = state_q == DONE;
        error_o     = error_q;
    end
endmodule

// File: tb/tb_shader_program_loader.sv
// tb_shader_program_loader: directed self-checking bench for the shader program loader.
module tb_shader_program_loader;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] wr_instr_i = '0;
    logic       wr_valid_i = 1'b0;
    logic       commit_i = 1'b0;
    logic       vblank_i = 1'b0;
    logic       execute_i = 1'b0;
    logic       wr_ready_o, mem_shift_o, mem_load_o, busy_o, swap_done_o, error_o;
    logic [7:0] mem_instr_o;
    int         checks = 0;
    int         errors = 0;

    shader_program_loader #(.NUM_INSTR(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_instr_i  (wr_instr_i),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .commit_i    (commit_i),
        .vblank_i    (vblank_i),
        .execute_i   (execute_i),
        .mem_shift_o (mem_shift_o),
        .mem_load_o  (mem_load_o),
        .mem_instr_o (mem_instr_o),
        .busy_o      (busy_o),
        .swap_done_o (swap_done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Writes 16 words base..base+15; commit rides with the last write when requested.
    task automatic write16(input logic [7:0] base, input logic with_commit);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            wr_valid_i = 1'b1;
            wr_instr_i = base + 8'(i);
            commit_i   = with_commit && (i == 15);
            #1 chk("wr_ready_fill", wr_ready_o, 1'b1);
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        commit_i   = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_wr_ready", wr_ready_o, 1'b1);
        chk("rst_load", mem_load_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_swap_done", swap_done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        execute_i = 1'b1;
        #1 chk("rst_shift_pass1", mem_shift_o, 1'b1);
        execute_i = 1'b0;
        #1 chk("rst_shift_pass0", mem_shift_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Full program with commit on the 16th write, vblank already high.
        vblank_i = 1'b1;
        write16(8'h10, 1'b1);
        #1;
        chk("armed_busy", busy_o, 1'b1);
        chk("armed_load", mem_load_o, 1'b0);
        chk("armed_ready", wr_ready_o, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            #1;
            chk("full_load", mem_load_o, 1'b1);
            chk("full_shift", mem_shift_o, 1'b1);
            chk("full_instr", mem_instr_o, 8'h10 + 8'(i));
        end
        @(negedge clk_i);
        #1;
        chk("full_swap_done", swap_done_o, 1'b1);
        chk("full_done_load", mem_load_o, 1'b0);
        chk("full_done_busy", busy_o, 1'b1);
        @(negedge clk_i);
        #1;
        chk("full_idle_swap", swap_done_o, 1'b0);
        chk("full_idle_busy", busy_o, 1'b0);
        chk("full_idle_ready", wr_ready_o, 1'b1);
        chk("full_error", error_o, 1'b0);

        // Short program: 5 words then a separate commit.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            wr_valid_i = 1'b1;
            wr_instr_i = 8'h50 + 8'(i);
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        commit_i   = 1'b1;
        @(negedge clk_i);
        commit_i = 1'b0;
        #1;
        chk("short_error", error_o, 1'b1);
        chk("short_count", 8'(dut.count), 8'h00);
        chk("short_busy", busy_o, 1'b0);
        chk("short_ready", wr_ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1 chk("short_no_load", mem_load_o, 1'b0);
        end

        do_reset();
        #1 chk("reset_clears_error", error_o, 1'b0);

        // Fill, then a dropped 17th word, then commit during active video.
        vblank_i = 1'b0;
        write16(8'h20, 1'b0);
        wr_valid_i = 1'b1;
        wr_instr_i = 8'hEE;
        #1 chk("overfull_ready", wr_ready_o, 1'b0);
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        commit_i   = 1'b1;
        #1 chk("overfull_count", 8'(dut.count), 8'h10);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            commit_i  = 1'b0;
            execute_i = (i % 3) == 0;
            #1;
            chk("video_shift", mem_shift_o, execute_i);
            chk("video_load", mem_load_o, 1'b0);
            chk("video_busy", busy_o, 1'b1);
        end
        @(negedge clk_i);
        execute_i = 1'b0;
        vblank_i  = 1'b1;
        #1 chk("vblank_rise_load", mem_load_o, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            execute_i = (i == 3);
            #1;
            chk("exec_load", mem_load_o, 1'b1);
            chk("exec_shift", mem_shift_o, 1'b1);
            chk("exec_instr", mem_instr_o, 8'h20 + 8'(i));
            if (i == 4) chk("exec_error_set", error_o, 1'b1);
        end
        @(negedge clk_i);
        execute_i = 1'b0;
        #1;
        chk("exec_swap_done", swap_done_o, 1'b1);
        chk("exec_error_sticky", error_o, 1'b1);

        // Reset in the 8th load cycle.
        do_reset();
        vblank_i = 1'b1;
        write16(8'h30, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            #1 chk("midrst_instr", mem_instr_o, 8'h30 + 8'(i));
        end
        rst_ni    = 1'b0;
        execute_i = 1'b1;
        #1;
        chk("midrst_load", mem_load_o, 1'b0);
        chk("midrst_shift", mem_shift_o, 1'b1);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_swap", swap_done_o, 1'b0);
        chk("midrst_error", error_o, 1'b0);
        chk("midrst_ready", wr_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        execute_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("post_rst_ready", wr_ready_o, 1'b1);
        chk("post_rst_busy", busy_o, 1'b0);
        chk("post_rst_load", mem_load_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
